// File: rtl/rxfifo_strm_arb_pkg.sv
// rxfifo_arb_pkg: shared types and source ids for the RX FIFO stream arbiter.
package rxfifo_arb_pkg;
    typedef enum logic [2:0] {IDLE, GNT0, GNT1, ABORT, DRAIN} arb_state_t;
    typedef logic [1:0] grant_t;
    localparam logic SRC_SERIAL = 1'b0;
    localparam logic SRC_BIDIR  = 1'b1;
endpackage

// File: rtl/rxfifo_strm_arb_skid.sv
// axis_skid_buf: 2-entry registered AXI-stream slice; ready only drops when both entries are held.
module axis_skid_buf #(
    parameter int DW = 32,
    parameter int UW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] s_tdata_i,
    input  logic [UW-1:0] s_tuser_i,
    input  logic          s_tlast_i,
    input  logic          s_tvalid_i,
    output logic          s_tready_o,
    output logic [DW-1:0] m_tdata_o,
    output logic [UW-1:0] m_tuser_o,
    output logic          m_tlast_o,
    output logic          m_tvalid_o,
    input  logic          m_tready_i
);
    localparam int PW = DW + UW + 1;
    logic [PW-1:0] in_w, out_q, out_d, sk_q, sk_d;
    logic          out_vld_q, out_vld_d, sk_vld_q, sk_vld_d, push, load;

    assign in_w       = {s_tlast_i, s_tuser_i, s_tdata_i};
    assign s_tready_o = !sk_vld_q;
    assign push       = s_tvalid_i && !sk_vld_q;
    assign load       = !out_vld_q || m_tready_i;
    assign out_vld_d  = load ? (sk_vld_q || push) : out_vld_q;
    assign out_d      = !load ? out_q : sk_vld_q ? sk_q : push ? in_w : out_q;
    assign sk_vld_d   = load ? 1'b0 : (sk_vld_q || push);
    assign sk_d       = (!load && push) ? in_w : sk_q;
    assign {m_tlast_o, m_tuser_o, m_tdata_o} = out_q;
    assign m_tvalid_o = out_vld_q;

    // output register refills from the skid entry first so beat order is kept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q     <= '0;
            sk_q      <= '0;
            out_vld_q <= 1'b0;
            sk_vld_q  <= 1'b0;
        end else begin
            out_q     <= out_d;
            sk_q      <= sk_d;
            out_vld_q <= out_vld_d;
            sk_vld_q  <= sk_vld_d;
        end
    end
endmodule

// File: rtl/rxfifo_strm_arb.sv
// rxfifo_strm_arb: packet-aware round-robin 2:1 AXI-stream merge in front of the RX FIFO.
// Define RXFIFO_STRM_ARB_TIMEOUT_EN to abort and drain packets that stall mid-packet.
module rxfifo_strm_arb
    import rxfifo_arb_pkg::*;
#(
    parameter int DW   = 32,
    parameter int UW   = 4,
    parameter int CNTW = 16
`ifdef RXFIFO_STRM_ARB_TIMEOUT_EN
    ,
    parameter int TMO_CYC = 1024
`endif
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            arb_en,
    input  logic [DW-1:0]   s0_tdata,
    input  logic [UW-1:0]   s0_tuser,
    input  logic            s0_tlast,
    input  logic            s0_tvalid,
    output logic            s0_tready,
    input  logic [DW-1:0]   s1_tdata,
    input  logic [UW-1:0]   s1_tuser,
    input  logic            s1_tlast,
    input  logic            s1_tvalid,
    output logic            s1_tready,
    output logic [DW-1:0]   m_tdata,
    output logic [UW-1:0]   m_tuser,
    output logic            m_tlast,
    output logic            m_tvalid,
    input  logic            m_tready,
    output grant_t          grant,
    output logic [CNTW-1:0] pkt_cnt0,
    output logic [CNTW-1:0] pkt_cnt1,
    output logic [CNTW-1:0] abort_cnt
);
    arb_state_t      state_q, state_d;
    logic            last_q, last_d;
    logic [CNTW-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
    logic            own, in_gnt, in_abort, in_drain, pick;
    logic            sel_vld, sel_last, sel_rdy, acc, sk_vld, sk_rdy;
    logic [DW-1:0]   sel_data;
    logic [UW-1:0]   sel_user;

`ifdef RXFIFO_STRM_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TMO_CYC + 1);
    logic            own_q, own_d;
    logic [TW-1:0]   stall_q, stall_d;
    logic [CNTW-1:0] abort_q, abort_d;
    assign in_abort  = state_q == ABORT;
    assign in_drain  = state_q == DRAIN;
    assign own       = own_q;
    assign abort_cnt = abort_q;
`else
    assign in_abort  = 1'b0;
    assign in_drain  = 1'b0;
    assign own       = state_q == GNT1;
    assign abort_cnt = '0;
`endif

    assign in_gnt    = (state_q == GNT0) || (state_q == GNT1);
    assign sel_vld   = own ? s1_tvalid : s0_tvalid;
    assign sel_last  = own ? s1_tlast  : s0_tlast;
    assign sel_data  = own ? s1_tdata  : s0_tdata;
    assign sel_user  = own ? s1_tuser  : s0_tuser;
    assign sel_rdy   = (in_gnt && sk_rdy) || in_drain;
    assign acc       = sel_vld && sel_rdy;
    assign s0_tready = sel_rdy && !own;
    assign s1_tready = sel_rdy && own;
    assign grant     = (in_gnt || in_abort || in_drain) ? (own ? 2'b10 : 2'b01) : 2'b00;
    assign pick      = (s0_tvalid && s1_tvalid) ? !last_q : s1_tvalid;
    assign sk_vld    = (in_gnt && sel_vld) || in_abort;
    assign pkt_cnt0  = cnt0_q;
    assign pkt_cnt1  = cnt1_q;

    axis_skid_buf #(.DW(DW), .UW(UW)) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_tdata_i  (in_abort ? '0 : sel_data),
        .s_tuser_i  (in_abort ? UW'(1) : sel_user),
        .s_tlast_i  (in_abort || sel_last),
        .s_tvalid_i (sk_vld),
        .s_tready_o (sk_rdy),
        .m_tdata_o  (m_tdata),
        .m_tuser_o  (m_tuser),
        .m_tlast_o  (m_tlast),
        .m_tvalid_o (m_tvalid),
        .m_tready_i (m_tready)
    );

    // grant at packet boundaries only; release and count on the accepted tlast
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt0_d  = cnt0_q;
        cnt1_d  = cnt1_q;
        if (state_q == IDLE && arb_en && (s0_tvalid || s1_tvalid))
            state_d = (pick == SRC_SERIAL) ? GNT0 : GNT1;
        if (in_gnt && acc && sel_last) begin
            state_d = IDLE;
            last_d  = own;
            cnt0_d  = own ? cnt0_q : cnt0_q + 1'b1;
            cnt1_d  = own ? cnt1_q + 1'b1 : cnt1_q;
        end
`ifdef RXFIFO_STRM_ARB_TIMEOUT_EN
        own_d   = (state_q == IDLE) ? pick : own_q;
        stall_d = (!in_gnt || acc) ? '0 : stall_q + TW'(!sel_vld);
        abort_d = abort_q;
        if (in_gnt && stall_d == TW'(TMO_CYC))
            state_d = ABORT;
        if (in_abort && sk_rdy) begin
            state_d = DRAIN;
            abort_d = abort_q + 1'b1;
        end
        if (in_drain && acc && sel_last) begin
            state_d = IDLE;
            last_d  = own;
        end
`endif
    end

    // arbiter state, round-robin pointer (last served source) and packet counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= SRC_BIDIR;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
        end
    end

`ifdef RXFIFO_STRM_ARB_TIMEOUT_EN
    // owner of an aborted packet, stall timer and abort counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            own_q   <= SRC_SERIAL;
            stall_q <= '0;
            abort_q <= '0;
        end else begin
            own_q   <= own_d;
            stall_q <= stall_d;
            abort_q <= abort_d;
        end
    end
`endif
endmodule

// File: tb/tb_rxfifo_strm_arb.sv
// tb_rxfifo_strm_arb: table-driven and sequence checks for the RX FIFO stream arbiter.
module tb_rxfifo_strm_arb;
    typedef logic [36:0] beat_t;
    typedef struct {
        logic        arb, v0, l0;
        logic [31:0] d0;
        logic        v1, l1;
        logic [31:0] d1;
        logic        mv;
        logic [31:0] md;
        logic        ml;
        logic [1:0]  gnt;
        logic        r0, r1;
        logic [15:0] c0, c1;
    } vec_t;

    logic        clk = 0, rst_n = 1, arb_en = 1, m_tready = 1;
    logic [31:0] s0_tdata = 0, s1_tdata = 0, m_tdata;
    logic [3:0]  s0_tuser = 0, s1_tuser = 0, m_tuser;
    logic        s0_tlast = 0, s0_tvalid = 0, s0_tready;
    logic        s1_tlast = 0, s1_tvalid = 0, s1_tready;
    logic        m_tlast, m_tvalid;
    logic [1:0]  grant;
    logic [15:0] pkt_cnt0, pkt_cnt1, abort_cnt;
    int          n_chk = 0, n_fail = 0;
    beat_t       got[$], exp_q[$];
    vec_t        tbl[18];
    logic        hold = 0;
    beat_t       prev = 0;

    rxfifo_strm_arb #(
        .DW(32), .UW(4), .CNTW(16)
`ifdef RXFIFO_STRM_ARB_TIMEOUT_EN
        , .TMO_CYC(16)
`endif
    ) dut (
        .clk(clk), .rst_n(rst_n), .arb_en(arb_en),
        .s0_tdata(s0_tdata), .s0_tuser(s0_tuser), .s0_tlast(s0_tlast), .s0_tvalid(s0_tvalid), .s0_tready(s0_tready),
        .s1_tdata(s1_tdata), .s1_tuser(s1_tuser), .s1_tlast(s1_tlast), .s1_tvalid(s1_tvalid), .s1_tready(s1_tready),
        .m_tdata(m_tdata), .m_tuser(m_tuser), .m_tlast(m_tlast), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .grant(grant), .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1), .abort_cnt(abort_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    function automatic vec_t mk(input logic arb, v0, l0, input logic [31:0] d0, input logic v1, l1,
                                input logic [31:0] d1, input logic mv, input logic [31:0] md, input logic ml,
                                input logic [1:0] gnt, input logic r0, r1, input logic [15:0] c0, c1);
        vec_t v;
        v.arb = arb; v.v0 = v0; v.l0 = l0; v.d0 = d0; v.v1 = v1; v.l1 = l1; v.d1 = d1;
        v.mv = mv; v.md = md; v.ml = ml; v.gnt = gnt; v.r0 = r0; v.r1 = r1; v.c0 = c0; v.c1 = c1;
        return v;
    endfunction

    function automatic beat_t bt(input logic [3:0] u, input logic l, input logic [31:0] d);
        return {u, l, d};
    endfunction

    // one source beat, held until accepted (bounded)
    task automatic send(input logic src, input logic [31:0] d, input logic l);
        int   n = 0;
        logic r;
        if (src) begin s1_tvalid = 1; s1_tdata = d; s1_tlast = l; end
        else begin s0_tvalid = 1; s0_tdata = d; s0_tlast = l; end
        do begin
            @(negedge clk);
            r = src ? s1_tready : s0_tready;
            @(posedge clk);
            #1;
            n++;
        end while (!r && n < 200);
        if (!r) begin
            n_chk++; n_fail++;
            $display("FAIL send src%0d: no tready within 200 cycles", src);
        end
        if (src) s1_tvalid = 0; else s0_tvalid = 0;
    endtask

    task automatic wait_beats(input int n);
        for (int i = 0; i < 300 && got.size() < n; i++) @(posedge clk);
        #1;
    endtask

    task automatic cmp_q(input string name);
        chk({name, " beat count"}, 64'(got.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (i < got.size()) chk($sformatf("%s beat %0d", name, i), 64'(got[i]), 64'(exp_q[i]));
    endtask

    // collect transferred beats and check output stability under back-pressure
    always @(negedge clk) begin
        if (rst_n && m_tvalid && m_tready) got.push_back({m_tuser, m_tlast, m_tdata});
        if (rst_n && hold) chk("stall stable", {m_tvalid, m_tuser, m_tlast, m_tdata}, {1'b1, prev});
        hold = rst_n && m_tvalid && !m_tready;
        prev = {m_tuser, m_tlast, m_tdata};
    end

    initial begin
        tbl[0]  = mk(1, 1, 0, 32'hA0, 0, 0, 0,      0, 0,      0, 2'b00, 0, 0, 0, 0);
        tbl[1]  = mk(1, 1, 0, 32'hA0, 0, 0, 0,      0, 0,      0, 2'b01, 1, 0, 0, 0);
        tbl[2]  = mk(1, 1, 0, 32'hA1, 0, 0, 0,      1, 32'hA0, 0, 2'b01, 1, 0, 0, 0);
        tbl[3]  = mk(1, 1, 1, 32'hA2, 0, 0, 0,      1, 32'hA1, 0, 2'b01, 1, 0, 0, 0);
        tbl[4]  = mk(1, 0, 0, 0,      0, 0, 0,      1, 32'hA2, 1, 2'b00, 0, 0, 1, 0);
        tbl[5]  = mk(1, 0, 0, 0,      0, 0, 0,      0, 0,      0, 2'b00, 0, 0, 1, 0);
        tbl[6]  = mk(1, 0, 0, 0,      1, 0, 32'hB0, 0, 0,      0, 2'b00, 0, 0, 1, 0);
        tbl[7]  = mk(1, 0, 0, 0,      1, 0, 32'hB0, 0, 0,      0, 2'b10, 0, 1, 1, 0);
        tbl[8]  = mk(0, 1, 1, 32'hC0, 1, 0, 32'hB1, 1, 32'hB0, 0, 2'b10, 0, 1, 1, 0);
        tbl[9]  = mk(0, 1, 1, 32'hC0, 1, 0, 32'hB2, 1, 32'hB1, 0, 2'b10, 0, 1, 1, 0);
        tbl[10] = mk(0, 1, 1, 32'hC0, 1, 1, 32'hB3, 1, 32'hB2, 0, 2'b10, 0, 1, 1, 0);
        tbl[11] = mk(0, 1, 1, 32'hC0, 0, 0, 0,      1, 32'hB3, 1, 2'b00, 0, 0, 1, 1);
        tbl[12] = mk(0, 1, 1, 32'hC0, 0, 0, 0,      0, 0,      0, 2'b00, 0, 0, 1, 1);
        tbl[13] = mk(0, 1, 1, 32'hC0, 0, 0, 0,      0, 0,      0, 2'b00, 0, 0, 1, 1);
        tbl[14] = mk(1, 1, 1, 32'hC0, 0, 0, 0,      0, 0,      0, 2'b00, 0, 0, 1, 1);
        tbl[15] = mk(1, 1, 1, 32'hC0, 0, 0, 0,      0, 0,      0, 2'b01, 1, 0, 1, 1);
        tbl[16] = mk(1, 0, 0, 0,      0, 0, 0,      1, 32'hC0, 1, 2'b00, 0, 0, 2, 1);
        tbl[17] = mk(1, 0, 0, 0,      0, 0, 0,      0, 0,      0, 2'b00, 0, 0, 2, 1);

        #1 rst_n = 0;
        #3;
        chk("reset m_tvalid", m_tvalid, 0);
        chk("reset m_tdata", m_tdata, 0);
        chk("reset m_tlast/tuser", {m_tlast, m_tuser}, 0);
        chk("reset tready", {s0_tready, s1_tready}, 0);
        chk("reset grant", grant, 0);
        chk("reset counters", {pkt_cnt0, pkt_cnt1, abort_cnt}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 18; i++) begin
            arb_en = tbl[i].arb;
            s0_tvalid = tbl[i].v0; s0_tlast = tbl[i].l0; s0_tdata = tbl[i].d0;
            s1_tvalid = tbl[i].v1; s1_tlast = tbl[i].l1; s1_tdata = tbl[i].d1;
            @(negedge clk);
            chk($sformatf("vec%0d m_tvalid", i), m_tvalid, tbl[i].mv);
            if (tbl[i].mv) begin
                chk($sformatf("vec%0d m_tdata", i), m_tdata, tbl[i].md);
                chk($sformatf("vec%0d m_tlast", i), m_tlast, tbl[i].ml);
            end
            chk($sformatf("vec%0d grant", i), grant, tbl[i].gnt);
            chk($sformatf("vec%0d tready", i), {s0_tready, s1_tready}, {tbl[i].r0, tbl[i].r1});
            chk($sformatf("vec%0d pkt_cnt", i), {pkt_cnt0, pkt_cnt1}, {tbl[i].c0, tbl[i].c1});
            @(posedge clk);
            #1;
        end

        // 8-beat packet with m_tready toggling every cycle
        got.delete(); exp_q.delete();
        fork
            for (int j = 0; j < 8; j++) send(1'b0, 32'hC300_0000 + 32'(j), j == 7);
            for (int k = 0; k < 40; k++) begin @(posedge clk); #1; m_tready = ~m_tready; end
        join
        m_tready = 1;
        for (int j = 0; j < 8; j++) exp_q.push_back(bt(0, j == 7, 32'hC300_0000 + 32'(j)));
        wait_beats(8);
        cmp_q("toggle");
        chk("toggle pkt_cnt0", pkt_cnt0, 3);

        // reset pulse in the middle of a src1 packet
        s1_tvalid = 1; s1_tdata = 32'hD100_0000; s1_tlast = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("pre-reset grant", grant, 2'b10);
        chk("pre-reset m_tvalid", m_tvalid, 1);
        #2 rst_n = 0;
        #1;
        chk("async reset m_tvalid", m_tvalid, 0);
        chk("async reset m_tdata", m_tdata, 0);
        chk("async reset grant", grant, 0);
        chk("async reset s1_tready", s1_tready, 0);
        chk("async reset pkt_cnt0", pkt_cnt0, 0);
        s1_tvalid = 0;
        @(posedge clk);
        #1 rst_n = 1;
        @(posedge clk);
        #1;

        // both sources stream 4-beat packets back to back; src0 goes first after reset
        got.delete(); exp_q.delete();
        fork
            for (int p = 0; p < 2; p++)
                for (int j = 0; j < 4; j++) send(1'b0, 32'h0A00_0000 + 32'(p * 256 + j), j == 3);
            for (int p = 0; p < 2; p++)
                for (int j = 0; j < 4; j++) send(1'b1, 32'h0B00_0000 + 32'(p * 256 + j), j == 3);
        join
        for (int p = 0; p < 2; p++)
            for (int s = 0; s < 2; s++)
                for (int j = 0; j < 4; j++)
                    exp_q.push_back(bt(0, j == 3, (s == 0 ? 32'h0A00_0000 : 32'h0B00_0000) + 32'(p * 256 + j)));
        wait_beats(16);
        cmp_q("rr");
        chk("rr pkt counts", {pkt_cnt0, pkt_cnt1}, {16'd2, 16'd2});

`ifdef RXFIFO_STRM_ARB_TIMEOUT_EN
        // src0 stalls mid-packet: abort beat, rest of packet drained, then src1 served
        got.delete(); exp_q.delete();
        fork
            begin
                send(1'b0, 32'hE000_0000, 0);
                send(1'b0, 32'hE000_0001, 0);
                repeat (20) @(posedge clk);
                #1;
                send(1'b0, 32'hE000_0002, 0);
                send(1'b0, 32'hE000_0003, 1);
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                send(1'b1, 32'hF000_0000, 0);
                send(1'b1, 32'hF000_0001, 1);
            end
        join
        exp_q.push_back(bt(0, 0, 32'hE000_0000));
        exp_q.push_back(bt(0, 0, 32'hE000_0001));
        exp_q.push_back(bt(4'h1, 1, 32'h0));
        exp_q.push_back(bt(0, 0, 32'hF000_0000));
        exp_q.push_back(bt(0, 1, 32'hF000_0001));
        wait_beats(5);
        cmp_q("timeout");
        chk("timeout abort_cnt", abort_cnt, 1);
        chk("timeout pkt counts", {pkt_cnt0, pkt_cnt1}, {16'd2, 16'd3});
`else
        chk("abort_cnt tied", abort_cnt, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
